bcd_countdown_timer: RTL and testbench

Two-digit BCD countdown timer that drives the seven-segment digit decoders downstream. It produces one 4-bit BCD digit per display plus the blank flag consumed as the decoder's `state` input (1 = segments off). The blank flag blinks when the count expires. It sits between the board push-button/switch logic and the per-digit seven-segment decoders.

---
 rtl/bcd_countdown_timer_pkg.sv | 19 +
 rtl/bcd_countdown_timer_if.sv | 26 ++
 rtl/bcd_countdown_timer_tick_divider.sv | 37 +++
 rtl/bcd_countdown_timer.sv | 139 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the FSM encoding, BCD limit, blank polarity and a nibble clamp.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic       BLANK_ON = 1'b1;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/display bundle between board controls, timer and digit decoders.
// master: drives start/pause/load/load_val; slave: drives digits and status.
interface bcd_countdown_timer_if;
    import timer_pkg::*;

    logic       start;
    logic       pause;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       state;
    logic       running;
    logic       done;

    modport master (
        output start, pause, load, load_val,
        input  ones, tens, state, running, done
    );

    modport slave (
        input  start, pause, load, load_val,
        output ones, tens, state, running, done
    );

endinterface

// File: rtl/bcd_countdown_timer_tick_divider.sv
// Modulo-N counter with enable and synchronous clear.
// Ports: clk, rst, en_i, clr_i (clear wins over enable), wrap_o (1-cycle pulse at N-1).
module tick_divider #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);
    localparam int unsigned W = (N > 2) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer feeding seven-segment decoders, blinks on expiry.
// Ports: clk, rst (sync, active-high), bus (slave): controls in, digits/blank/status out.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter logic [7:0]  START_VAL = 8'h59
) (
    input  logic clk,
    input  logic rst,
    bcd_countdown_timer_if.slave bus
);
    state_e     fsm_q, fsm_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [7:0] preset_q, preset_d;
    logic       blank_q, blank_d;

    logic       tick_en, tick_clr, tick;
    logic       blink_en, blink_clr, blink;
    logic [7:0] load_clamped;

    assign load_clamped = {bcd_clamp(bus.load_val[7:4]),
                           bcd_clamp(bus.load_val[3:0])};

    // A pause cycle must not advance the prescaler, so resume keeps the phase.
    assign tick_en   = (fsm_q == ST_RUN) && !bus.pause;
    // Blink counter is cleared whenever the next state leaves DONE.
    assign blink_en  = (fsm_q == ST_DONE);
    assign blink_clr = (fsm_d != ST_DONE);

    tick_divider #(.N(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (tick_en),
        .clr_i  (tick_clr),
        .wrap_o (tick)
    );

    tick_divider #(.N(BLINK_DIV)) u_blink (
        .clk    (clk),
        .rst    (rst),
        .en_i   (blink_en),
        .clr_i  (blink_clr),
        .wrap_o (blink)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= ST_IDLE;
            ones_q   <= START_VAL[3:0];
            tens_q   <= START_VAL[7:4];
            preset_q <= START_VAL;
            blank_q  <= ~BLANK_ON;
        end else begin
            fsm_q    <= fsm_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            preset_q <= preset_d;
            blank_q  <= blank_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        preset_d = preset_q;
        tick_clr = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (bus.load) begin
                    preset_d = load_clamped;
                    {tens_d, ones_d} = load_clamped;
                    tick_clr = 1'b1;
                end else if (bus.start) begin
                    tick_clr = 1'b1;
                    fsm_d = ({tens_q, ones_q} == 8'h00) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.pause) begin
                    fsm_d = ST_PAUSE;
                end else if (tick) begin
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = BCD_MAX;
                        tens_d = tens_q - 4'd1;
                    end
                    if (tens_q == 4'd0 && ones_q == 4'd1) begin
                        fsm_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.load) begin
                    preset_d = load_clamped;
                    {tens_d, ones_d} = load_clamped;
                    tick_clr = 1'b1;
                    fsm_d = ST_IDLE;
                end else if (bus.start) begin
                    fsm_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.load) begin
                    preset_d = load_clamped;
                    {tens_d, ones_d} = load_clamped;
                    tick_clr = 1'b1;
                    fsm_d = ST_IDLE;
                end else if (bus.start) begin
                    {tens_d, ones_d} = preset_q;
                    tick_clr = 1'b1;
                    fsm_d = (preset_q != 8'h00) ? ST_RUN : ST_DONE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Blank toggles only while staying in DONE; entering DONE forces it off.
    always_comb begin
        blank_d = ~BLANK_ON;
        if (fsm_q == ST_DONE && fsm_d == ST_DONE) begin
            blank_d = blink ? ~blank_q : blank_q;
        end
    end

    always_comb begin
        bus.ones    = ones_q;
        bus.tens    = tens_q;
        bus.state   = blank_q;
        bus.running = (fsm_q == ST_RUN);
        bus.done    = (fsm_q == ST_DONE);
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed plan plus random traffic.
// Compares every cycle against an integer-valued behavioural model.
module tb_bcd_countdown_timer;

    localparam int unsigned TICK  = 4;
    localparam int unsigned BLINK = 3;
    localparam logic [7:0]  START = 8'h59;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errs   = 0;
    int checks = 0;

    bcd_countdown_timer_if bus ();

    bcd_countdown_timer #(
        .TICK_DIV  (TICK),
        .BLINK_DIV (BLINK),
        .START_VAL (START)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: 0=idle 1=run 2=pause 3=done; count held as plain integer 0..99.
    int m_mode;
    int m_cnt;
    int m_pre;
    int m_pc;
    int m_bc;
    bit m_blank;

    function automatic int clampv(input logic [7:0] v);
        int t;
        int o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        return t * 10 + o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic enter_done();
        m_mode  = 3;
        m_bc    = 0;
        m_blank = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit p,
                              input bit l, input logic [7:0] v);
        if (r) begin
            m_mode  = 0;
            m_cnt   = clampv(START);
            m_pre   = clampv(START);
            m_pc    = 0;
            m_bc    = 0;
            m_blank = 1'b0;
            return;
        end
        case (m_mode)
            0: begin
                if (l) begin
                    m_pre = clampv(v);
                    m_cnt = m_pre;
                end else if (s) begin
                    if (m_cnt == 0) enter_done();
                    else begin
                        m_mode = 1;
                        m_pc   = 0;
                    end
                end
            end
            1: begin
                if (p) m_mode = 2;
                else begin
                    m_pc++;
                    if (m_pc == TICK) begin
                        m_pc = 0;
                        m_cnt--;
                        if (m_cnt == 0) enter_done();
                    end
                end
            end
            2: begin
                if (l) begin
                    m_pre  = clampv(v);
                    m_cnt  = m_pre;
                    m_mode = 0;
                end else if (s) m_mode = 1;
            end
            default: begin
                if (l) begin
                    m_pre   = clampv(v);
                    m_cnt   = m_pre;
                    m_mode  = 0;
                    m_blank = 1'b0;
                end else if (s && m_pre != 0) begin
                    m_cnt   = m_pre;
                    m_mode  = 1;
                    m_pc    = 0;
                    m_blank = 1'b0;
                end else begin
                    if (s) m_cnt = m_pre;
                    m_bc++;
                    if (m_bc == BLINK) begin
                        m_bc    = 0;
                        m_blank = !m_blank;
                    end
                end
            end
        endcase
    endtask

    task automatic step(input bit r, input bit s, input bit p,
                        input bit l, input logic [7:0] v);
        rst          = r;
        bus.start    = s;
        bus.pause    = p;
        bus.load     = l;
        bus.load_val = v;
        @(posedge clk);
        model_step(r, s, p, l, v);
        #1;
        check("tens", 32'(bus.tens), 32'(m_cnt / 10));
        check("ones", 32'(bus.ones), 32'(m_cnt % 10));
        check("state", 32'(bus.state), 32'(m_blank));
        check("running", 32'(bus.running), 32'(m_mode == 1));
        check("done", 32'(bus.done), 32'(m_mode == 3));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'h00;

        // Reset values and first decrement latency
        step(1, 0, 0, 0, 8'h00);
        check("rst_tens", 32'(bus.tens), 32'd5);
        check("rst_ones", 32'(bus.ones), 32'd9);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_run", 32'(bus.running), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        step(0, 1, 0, 0, 8'h00);
        check("t1_run", 32'(bus.running), 32'd1);
        idle(3);
        check("t1_hold", 32'(bus.ones), 32'd9);
        idle(1);
        check("t1_dec", 32'(bus.ones), 32'd8);

        // Borrow, expiry and blink
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 1, 8'h10);
        step(0, 1, 0, 0, 8'h00);
        idle(4);
        check("t2_borrow", 32'({bus.tens, bus.ones}), 32'h09);
        idle(36);
        check("t2_zero", 32'({bus.tens, bus.ones}), 32'h00);
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_st0", 32'(bus.state), 32'd0);
        idle(3);
        check("t2_st1", 32'(bus.state), 32'd1);
        idle(3);
        check("t2_st2", 32'(bus.state), 32'd0);

        // Clamp and zero start
        step(0, 0, 0, 1, 8'hA3);
        check("t3_clamp", 32'({bus.tens, bus.ones}), 32'h93);
        step(0, 0, 0, 1, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        check("t3_done", 32'(bus.done), 32'd1);
        check("t3_norun", 32'(bus.running), 32'd0);

        // Pause holds prescaler phase
        step(0, 0, 0, 1, 8'h25);
        step(0, 1, 0, 0, 8'h00);
        idle(2);
        step(0, 0, 1, 0, 8'h00);
        idle(10);
        check("t4_hold", 32'({bus.tens, bus.ones}), 32'h25);
        step(0, 1, 0, 0, 8'h00);
        idle(1);
        check("t4_pre", 32'({bus.tens, bus.ones}), 32'h25);
        idle(1);
        check("t4_dec", 32'({bus.tens, bus.ones}), 32'h24);

        // Load ignored in RUN; load beats start in DONE
        step(0, 0, 0, 1, 8'h42);
        check("t5_ign", 32'(bus.running), 32'd1);
        check("t5_tens", 32'(bus.tens), 32'd2);
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 1, 8'h01);
        step(0, 1, 0, 0, 8'h00);
        idle(4);
        check("t5_done", 32'(bus.done), 32'd1);
        step(0, 1, 0, 1, 8'h42);
        check("t5_ld", 32'({bus.tens, bus.ones}), 32'h42);
        check("t5_run", 32'(bus.running), 32'd0);
        check("t5_dn", 32'(bus.done), 32'd0);

        // Reset mid-DONE and restart from preset
        step(0, 0, 0, 1, 8'h01);
        step(0, 1, 0, 0, 8'h00);
        idle(7);
        check("t6_blink", 32'(bus.state), 32'd1);
        step(1, 0, 0, 0, 8'h00);
        check("t6_rst", 32'({bus.tens, bus.ones}), 32'h59);
        check("t6_st", 32'(bus.state), 32'd0);
        check("t6_dn", 32'(bus.done), 32'd0);
        step(0, 0, 0, 1, 8'h07);
        step(0, 1, 0, 0, 8'h00);
        idle(28);
        check("t6_exp", 32'(bus.done), 32'd1);
        step(0, 1, 0, 0, 8'h00);
        check("t6_run", 32'(bus.running), 32'd1);
        check("t6_re", 32'({bus.tens, bus.ones}), 32'h07);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) v = 8'($urandom);
            else v = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0,
                 v);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
